// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolve unit: FSM states and instruction size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_pkg;

    // RUN resolves branches in ID; SQUASH covers the one wrong-path slot after a flush.
    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } brs_state_t;

    // Fixed instruction size; fall-through PC is pc + INSN_BYTES.
    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Latency: count reflects an inc on the following rising edge.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on inc unless already at the maximum value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves ID-stage branches against the IF-time prediction; flushes and updates predictor.
// Latency: flush/redirect/update are combinational from the IF/ID record; counters lag one edge.
// Backpressure: stall freezes the IF/ID record and suppresses resolution until released.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             id_is_branch,
    input  logic             id_taken,
    input  logic [XLEN-1:0]  id_target,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic             upd_correct,
    output logic [XLEN-1:0]  upd_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    brs_state_t      state, state_nxt;

    // IF/ID record: the instruction now in ID plus what was predicted for it at fetch.
    logic            id_v;
    logic [XLEN-1:0] id_pc;
    logic            id_pt;
    logic [XLEN-1:0] id_ptgt;

    logic            resolve;
    logic            mispredict;
    logic            pred_wrong;

    // Prediction check independent of state; a predicted-taken non-branch is an alias hit.
    always_comb begin
        if (id_is_branch) begin
            pred_wrong = (id_pt != id_taken) || (id_pt && id_taken && (id_ptgt != id_target));
        end else begin
            pred_wrong = id_pt;
        end
    end

    // Next-state and resolution outputs; nothing resolves while squashing or stalled.
    always_comb begin
        state_nxt  = state;
        resolve    = 1'b0;
        mispredict = 1'b0;
        unique case (state)
            RUN: begin
                resolve    = id_v && !stall;
                mispredict = resolve && pred_wrong;
                if (mispredict) begin
                    state_nxt = SQUASH;
                end
            end
            SQUASH: begin
                if (!stall) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign flush       = mispredict;
    assign redirect_pc = (id_is_branch && id_taken) ? id_target : id_pc + XLEN'(INSN_BYTES);
    assign upd_valid   = resolve && id_is_branch;
    assign upd_correct = !mispredict;
    assign upd_pc      = id_pc;

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Advance the IF/ID record when not stalled; the slot fetched alongside a flush is wrong-path.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            id_v    <= 1'b0;
            id_pc   <= '0;
            id_pt   <= 1'b0;
            id_ptgt <= '0;
        end else if (!stall) begin
            id_v    <= if_valid && !mispredict;
            id_pc   <= if_pc;
            id_pt   <= pred_taken;
            id_ptgt <= pred_target;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (upd_valid),
        .count  (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mispred_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (upd_valid && !upd_correct),
        .count  (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed table, corner sequences, random vs model.
// Latency: inputs driven on falling edge, outputs sampled 2 time units later.
// Backpressure: stall exercised in directed and random phases.
module tb_branch_resolve_unit;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk;
    logic             arst_n;
    logic             stall;
    logic             if_valid;
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             id_is_branch;
    logic             id_taken;
    logic [XLEN-1:0]  id_target;
    logic             flush;
    logic [XLEN-1:0]  redirect_pc;
    logic             upd_valid;
    logic             upd_correct;
    logic [XLEN-1:0]  upd_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .stall        (stall),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .id_is_branch (id_is_branch),
        .id_taken     (id_taken),
        .id_target    (id_target),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_correct  (upd_correct),
        .upd_pc       (upd_pc),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            s;
        logic            ifv;
        logic [XLEN-1:0] ifpc;
        logic            pt;
        logic [XLEN-1:0] ptgt;
        logic            br;
        logic            tk;
        logic [XLEN-1:0] tgt;
        logic            e_fl;
        logic [XLEN-1:0] e_rd;
        logic            e_uv;
        logic            e_uc;
        logic [3:0]      e_bc;
        logic [3:0]      e_mc;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive on the falling edge, let combinational outputs settle.
    task automatic cyc(input logic s, input logic ifv, input logic [XLEN-1:0] ifpc,
                       input logic pt, input logic [XLEN-1:0] ptgt,
                       input logic br, input logic tk, input logic [XLEN-1:0] tgt);
        @(negedge clk);
        stall        = s;
        if_valid     = ifv;
        if_pc        = ifpc;
        pred_taken   = pt;
        pred_target  = ptgt;
        id_is_branch = br;
        id_taken     = tk;
        id_target    = tgt;
        #2;
    endtask

    task automatic zero_inputs();
        stall = 1'b0; if_valid = 1'b0; if_pc = '0; pred_taken = 1'b0; pred_target = '0;
        id_is_branch = 1'b0; id_taken = 1'b0; id_target = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Reference model state: the instruction sitting in ID and what was predicted for it.
    logic            m_v, m_pt, m_sq;
    logic [XLEN-1:0] m_pc, m_ptgt;
    int              m_bc, m_mc;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        zero_inputs();
        arst_n = 1'b0;
        #7;
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_upd_correct", 64'(upd_correct), 64'd1);
        chk("rst_redirect", redirect_pc, 64'h4);
        chk("rst_upd_pc", upd_pc, 64'h0);
        chk("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // ---------------- directed table ----------------
        //          s     ifv   ifpc                   pt    ptgt      br    tk    tgt        fl    rd                     uv    uc    bc     mc
        vt[0]  = '{1'b0, 1'b1, 64'h100,              1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    1'b0, 64'h4,                 1'b0, 1'b1, 4'd0, 4'd0};
        vt[1]  = '{1'b0, 1'b1, 64'h104,              1'b0, 64'h0,   1'b1, 1'b1, 64'h200,  1'b1, 64'h200,               1'b1, 1'b0, 4'd0, 4'd0};
        vt[2]  = '{1'b0, 1'b1, 64'h200,              1'b1, 64'h300, 1'b0, 1'b0, 64'h0,    1'b0, 64'h108,               1'b0, 1'b1, 4'd1, 4'd1};
        vt[3]  = '{1'b0, 1'b1, 64'h300,              1'b0, 64'h0,   1'b1, 1'b1, 64'h300,  1'b0, 64'h300,               1'b1, 1'b1, 4'd1, 4'd1};
        vt[4]  = '{1'b0, 1'b1, 64'h40,               1'b1, 64'h80,  1'b0, 1'b0, 64'h0,    1'b0, 64'h304,               1'b0, 1'b1, 4'd2, 4'd1};
        vt[5]  = '{1'b0, 1'b1, 64'h44,               1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    1'b1, 64'h44,                1'b0, 1'b0, 4'd2, 4'd1};
        vt[6]  = '{1'b0, 1'b1, 64'h44,               1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    1'b0, 64'h48,                1'b0, 1'b1, 4'd2, 4'd1};
        vt[7]  = '{1'b0, 1'b0, 64'h0,                1'b0, 64'h0,   1'b1, 1'b0, 64'h999,  1'b0, 64'h48,                1'b1, 1'b1, 4'd2, 4'd1};
        vt[8]  = '{1'b0, 1'b1, 64'h600,              1'b1, 64'h700, 1'b1, 1'b1, 64'h500,  1'b0, 64'h500,               1'b0, 1'b1, 4'd3, 4'd1};
        vt[9]  = '{1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0, 64'h0,   1'b1, 1'b1, 64'h704,  1'b1, 64'h704,               1'b1, 1'b0, 4'd3, 4'd1};
        vt[10] = '{1'b0, 1'b0, 64'h0,                1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    1'b0, 64'h0,                 1'b0, 1'b1, 4'd4, 4'd2};
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].s, vt[i].ifv, vt[i].ifpc, vt[i].pt, vt[i].ptgt, vt[i].br, vt[i].tk, vt[i].tgt);
            chk($sformatf("tbl%0d_flush", i), 64'(flush), 64'(vt[i].e_fl));
            chk($sformatf("tbl%0d_redirect", i), redirect_pc, vt[i].e_rd);
            chk($sformatf("tbl%0d_upd_valid", i), 64'(upd_valid), 64'(vt[i].e_uv));
            chk($sformatf("tbl%0d_upd_correct", i), 64'(upd_correct), 64'(vt[i].e_uc));
            chk($sformatf("tbl%0d_branch_cnt", i), 64'(branch_cnt), 64'(vt[i].e_bc));
            chk($sformatf("tbl%0d_mispred_cnt", i), 64'(mispred_cnt), 64'(vt[i].e_mc));
        end

        // ---------------- mispredicting branch held by stall ----------------
        cyc(1'b0, 1'b1, 64'h800, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        chk("stl_pre_flush", 64'(flush), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 64'h900, 1'b1, 64'h111, 1'b1, 1'b1, 64'hA00);
            chk($sformatf("stl%0d_flush", k), 64'(flush), 64'd0);
            chk($sformatf("stl%0d_upd_valid", k), 64'(upd_valid), 64'd0);
            chk($sformatf("stl%0d_branch_cnt", k), 64'(branch_cnt), 64'd4);
        end
        cyc(1'b0, 1'b1, 64'h900, 1'b1, 64'h111, 1'b1, 1'b1, 64'hA00);
        chk("stl_rel_flush", 64'(flush), 64'd1);
        chk("stl_rel_redirect", redirect_pc, 64'hA00);
        chk("stl_rel_upd_valid", 64'(upd_valid), 64'd1);
        chk("stl_rel_upd_correct", 64'(upd_correct), 64'd0);
        chk("stl_rel_upd_pc", upd_pc, 64'h800);
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        chk("stl_post_flush", 64'(flush), 64'd0);
        chk("stl_post_upd_valid", 64'(upd_valid), 64'd0);
        chk("stl_post_branch_cnt", 64'(branch_cnt), 64'd5);
        chk("stl_post_mispred_cnt", 64'(mispred_cnt), 64'd3);

        // ---------------- reset during SQUASH ----------------
        cyc(1'b0, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b1, 64'h104, 1'b0, 64'h0, 1'b1, 1'b1, 64'h200);
        chk("sqr_flush", 64'(flush), 64'd1);
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        #1 arst_n = 1'b0;
        #1;
        chk("sqr_rst_flush", 64'(flush), 64'd0);
        chk("sqr_rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("sqr_rst_upd_correct", 64'(upd_correct), 64'd1);
        chk("sqr_rst_redirect", redirect_pc, 64'h4);
        chk("sqr_rst_upd_pc", upd_pc, 64'h0);
        chk("sqr_rst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("sqr_rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        cyc(1'b0, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b1, 64'h104, 1'b0, 64'h0, 1'b1, 1'b1, 64'h200);
        chk("sqr_after_flush", 64'(flush), 64'd1);
        chk("sqr_after_upd_valid", 64'(upd_valid), 64'd1);
        chk("sqr_after_redirect", redirect_pc, 64'h200);
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        chk("sqr_after_branch_cnt", 64'(branch_cnt), 64'd1);
        chk("sqr_after_mispred_cnt", 64'(mispred_cnt), 64'd1);

        // ---------------- reset during stall discards the held branch ----------------
        cyc(1'b0, 1'b1, 64'h300, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h400);
        chk("stlr_flush", 64'(flush), 64'd0);
        #1 arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h400);
        chk("stlr_after_flush", 64'(flush), 64'd0);
        chk("stlr_after_upd_valid", 64'(upd_valid), 64'd0);
        chk("stlr_after_branch_cnt", 64'(branch_cnt), 64'd0);

        // ---------------- counter saturation: 17 correct branches ----------------
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, 1'b1, 64'h1000 + 64'(i * 4), 1'b0, 64'h0, (i > 0), 1'b0, 64'h0);
        end
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        chk("sat_branch_cnt", 64'(branch_cnt), 64'd15);
        chk("sat_mispred_cnt", 64'(mispred_cnt), 64'd0);

        // ---------------- random traffic against the reference model ----------------
        do_reset();
        m_v = 1'b0; m_pt = 1'b0; m_sq = 1'b0; m_pc = '0; m_ptgt = '0; m_bc = 0; m_mc = 0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0]     r;
            logic [XLEN-1:0] pc_r;
            logic            res, act_dir, wrong, e_mis, e_uv;
            logic [XLEN-1:0] e_rd;
            r    = $urandom;
            pc_r = (r[20:17] == 4'd0) ? 64'hFFFFFFFFFFFFFFFC : {56'h0, r[7:2], 2'b00};
            cyc(r[15] & r[16], r[13] | r[14], pc_r, r[10], r[8] ? 64'h10 : 64'h20,
                r[11], r[12], r[9] ? 64'h10 : 64'h20);

            // The ID instruction is judged only if it is real, not stalled, and not in the squash slot.
            res     = !m_sq && m_v && !stall;
            act_dir = id_is_branch && id_taken;
            wrong   = (m_pt != act_dir) || (m_pt && (m_ptgt != id_target));
            e_mis   = res && wrong;
            e_uv    = res && id_is_branch;
            e_rd    = act_dir ? id_target : m_pc + 64'd4;

            chk("rnd_flush", 64'(flush), 64'(e_mis));
            chk("rnd_redirect", redirect_pc, e_rd);
            chk("rnd_upd_valid", 64'(upd_valid), 64'(e_uv));
            chk("rnd_upd_correct", 64'(upd_correct), 64'(!e_mis));
            chk("rnd_upd_pc", upd_pc, m_pc);
            chk("rnd_branch_cnt", 64'(branch_cnt), 64'(m_bc));
            chk("rnd_mispred_cnt", 64'(mispred_cnt), 64'(m_mc));

            if (e_uv) begin
                m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
                if (e_mis) m_mc = (m_mc + 1 > CMAX) ? CMAX : m_mc + 1;
            end
            if (!stall) begin
                m_v    = if_valid && !e_mis;
                m_pc   = if_pc;
                m_pt   = pred_taken;
                m_ptgt = pred_target;
                m_sq   = e_mis;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC/target width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning performance-counter width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  pipeline stall; IF/ID hold their contents.
REQ-006 SHALL have port if_valid  input  1  IF stage holds a real instruction.
REQ-007 SHALL have port if_pc  input  XLEN  PC of the IF instruction.
REQ-008 SHALL have port pred_taken  input  1  predictor's taken decision for if_pc.
REQ-009 SHALL have port pred_target  input  XLEN  predictor's target for if_pc.
REQ-010 SHALL have port id_is_branch  input  1  ID instruction is a conditional branch.
REQ-011 SHALL have port id_taken  input  1  actual branch outcome computed in ID.
REQ-012 SHALL have port id_target  input  XLEN  actual branch target computed in ID.
REQ-013 SHALL have port flush  output  1  squash IF instruction and redirect fetch.
REQ-014 SHALL have port redirect_pc  output  XLEN  correct next fetch PC, valid when flush=1.
REQ-015 SHALL have port upd_valid  output  1  one-cycle predictor update strobe.
REQ-016 SHALL have port upd_correct  output  1  prediction correct; qualified by upd_valid.
REQ-017 SHALL have port upd_pc  output  XLEN  PC of the resolved branch; qualified by upd_valid.
REQ-018 SHALL have ports branch_cnt, mispred_cnt  output  CNT_W  resolved-branch and misprediction counts.

Function
REQ-019 SHALL register if_valid, if_pc, pred_taken, pred_target into an IF/ID record (id_v, id_pc, id_pt, id_ptgt) on every edge where stall=0; the record SHALL hold while stall=1.
REQ-020 SHALL implement FSM states RUN and SQUASH.
REQ-021 In RUN, SHALL define resolve = id_v & ~stall.
REQ-022 SHALL define mispredict = resolve & (id_is_branch ? (id_pt != id_taken) | (id_pt & id_taken & id_ptgt != id_target) : id_pt); a non-branch predicted taken (table alias) is a mispredict.
REQ-023 flush SHALL be combinational and equal mispredict (0 in SQUASH).
REQ-024 redirect_pc SHALL be id_target when id_is_branch & id_taken, else id_pc + 4 (modulo 2^XLEN, wrap allowed).
REQ-025 upd_valid SHALL be resolve & id_is_branch in RUN; upd_correct = ~mispredict; upd_pc = id_pc.
REQ-026 On mispredict, FSM SHALL go RUN->SQUASH; the instruction captured on that edge SHALL be recorded with id_v=0 (wrong path).
REQ-027 SQUASH SHALL return to RUN on the next edge with stall=0; remain in SQUASH while stall=1; produce no flush/upd_valid.
REQ-028 branch_cnt SHALL increment on each upd_valid; mispred_cnt on each upd_valid & ~upd_correct; both SHALL saturate at 2^CNT_W-1.
REQ-029 Non-branch mispredict SHALL raise flush but SHALL NOT raise upd_valid or change counters.
REQ-030 With stall=1 in RUN, flush, upd_valid and counters SHALL be inactive; resolution occurs on the first unstalled cycle, exactly once.

Reset
REQ-031 arst_n=0 SHALL immediately set FSM=RUN, id_v=0, id_pt=0, id_pc=id_ptgt=0, both counters 0; outputs flush=0, upd_valid=0, upd_correct=1, redirect_pc=4, upd_pc=0.
REQ-032 Reset asserted mid-SQUASH or mid-stall SHALL discard all pending state; first post-reset instruction resolves normally.

Structure
REQ-033 SHALL place state enum (RUN, SQUASH) and instruction-size constant (4) in shared package bp_pkg.
REQ-034 SHALL instantiate one saturating-counter sub-module, sat_counter (params WIDTH; ports clk, arst_n, inc, count), twice.

Verification
REQ-035 Branch at 0x100, pred_taken=0, actual taken to 0x200 -> flush=1, redirect_pc=0x200, upd_valid=1, upd_correct=0, mispred_cnt=1; next cycle no upd_valid.
REQ-036 Branch at 0x100, pred taken 0x200, actual taken 0x200 -> flush=0, upd_valid=1, upd_correct=1, branch_cnt=1, mispred_cnt=0.
REQ-037 Non-branch at 0x40, pred_taken=1 -> flush=1, redirect_pc=0x44, upd_valid=0, counters unchanged.
REQ-038 Mispredicting branch held with stall=1 for 3 cycles -> no flush during stall; single flush and single count on release.
REQ-039 CNT_W=4, 17 resolved branches -> branch_cnt stays 15.
REQ-040 arst_n pulsed low during SQUASH -> outputs at reset values immediately; next valid branch resolves in RUN.
